sdram_arbiter: RTL and testbench

Two-port burst arbiter that shares one sdram_ctrl instance between a write requester (camera pixel FIFO) and a read requester (display line fetch). It grants whole bursts of BURST_LEN words in round-robin order. For each granted burst it issues the single-cycle enable pulse, the address and the rw level to sdram_ctrl. It counts the controller's is_writing / o_dataval beats and steers data to the granted requester. Sits between the capture/display logic and sdram_ctrl in the camera top level.

---
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin burst arbiter sharing one sdram_ctrl between a write port and a read port.
// Grants whole bursts, issues the enable pulse, and steers beat data to the granted side.
module sdram_arbiter #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BURST_LEN   = 512,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_wr_pop,
  output logic              o_wr_done,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_done,
  output logic              o_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_sdram_en,
  output logic              o_rw,
  output logic [DATA_W-1:0] o_datain,
  input  logic              i_ready,
  input  logic              i_writing,
  input  logic              i_dataval,
  input  logic [DATA_W-1:0] i_dataout
);

  localparam int unsigned CntW = $clog2(BURST_LEN) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYC - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWrBurst, StRdBurst, StGap} state_e;

  state_e          state_q;
  logic [CntW-1:0] beat_cnt_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            last_rd_q;  // 1 = read was served last, so write wins a tie

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      last_rd_q  <= 1'b1;
      o_wr_ack   <= 1'b0;
      o_rd_ack   <= 1'b0;
      o_wr_done  <= 1'b0;
      o_rd_done  <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_err      <= 1'b0;
      o_addr     <= '0;
      o_rw       <= 1'b0;
      o_sdram_en <= 1'b0;
    end else begin
      o_sdram_en <= 1'b0;
      o_wr_ack   <= 1'b0;
      o_rd_ack   <= 1'b0;
      o_wr_done  <= 1'b0;
      o_rd_done  <= 1'b0;
      o_rd_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_ready && (i_wr_req || i_rd_req)) begin
            if (i_wr_req && (!i_rd_req || last_rd_q)) begin
              o_addr   <= i_wr_addr;
              o_rw     <= 1'b0;
              o_wr_ack <= 1'b1;
            end else begin
              o_addr   <= i_rd_addr;
              o_rw     <= 1'b1;
              o_rd_ack <= 1'b1;
            end
            o_sdram_en <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          beat_cnt_q <= '0;
          tmo_cnt_q  <= '0;
          state_q    <= o_rw ? StRdBurst : StWrBurst;
        end
        StWrBurst: begin
          tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          if (i_writing) beat_cnt_q <= beat_cnt_q + CntW'(1);
          // A completing beat takes priority over a coincident timeout
          if (i_writing && beat_cnt_q == LastBeat) begin
            o_wr_done <= 1'b1;
            last_rd_q <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end else if (tmo_cnt_q == TmoLast) begin
            o_err     <= 1'b1;
            last_rd_q <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end
        end
        StRdBurst: begin
          tmo_cnt_q  <= tmo_cnt_q + TmoW'(1);
          o_rd_valid <= i_dataval;
          if (i_dataval) begin
            beat_cnt_q <= beat_cnt_q + CntW'(1);
            o_rd_data  <= i_dataout;
          end
          if (i_dataval && beat_cnt_q == LastBeat) begin
            o_rd_done <= 1'b1;
            last_rd_q <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end else if (tmo_cnt_q == TmoLast) begin
            o_err     <= 1'b1;
            last_rd_q <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) state_q <= StIdle;
          else gap_cnt_q <= gap_cnt_q + GapW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write data path is combinational so the FIFO head reaches the controller on the beat itself
  assign o_wr_pop = (state_q == StWrBurst) && i_writing;
  assign o_datain = (state_q == StWrBurst) ? i_wr_data : '0;
  assign o_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a table of burst grants plus hand-written
// sequences for i_ready stall, timeout, and reset in the middle of a read.
module tb_sdram_arbiter;

  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 16;
  localparam int unsigned BL  = 32;  // burst shortened so a full burst fits the 64-cycle timeout
  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 64;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_wr_req = 1'b0, i_rd_req = 1'b0;
  logic [AW-1:0] i_wr_addr = '0, i_rd_addr = '0;
  logic [DW-1:0] i_wr_data = '0, i_dataout = '0;
  logic          i_ready = 1'b1, i_writing = 1'b0, i_dataval = 1'b0;
  logic          o_wr_ack, o_wr_pop, o_wr_done, o_rd_ack, o_rd_valid, o_rd_done;
  logic          o_err, o_busy, o_sdram_en, o_rw;
  logic [DW-1:0] o_rd_data, o_datain;
  logic [AW-1:0] o_addr;

  sdram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .o_wr_pop(o_wr_pop), .o_wr_done(o_wr_done),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_ack(o_rd_ack),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_done(o_rd_done),
    .o_err(o_err), .o_busy(o_busy), .o_addr(o_addr), .o_sdram_en(o_sdram_en),
    .o_rw(o_rw), .o_datain(o_datain), .i_ready(i_ready), .i_writing(i_writing),
    .i_dataval(i_dataval), .i_dataout(i_dataout)
  );

  always #5 i_clk = ~i_clk;

  int vec_cnt = 0;
  int miscmp  = 0;
  int cyc = 0, last_done = -1, en_cnt = 0, wdone_cnt = 0;
  logic prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus-level monitor: enable pulses never back to back, and a gap follows every done
  always @(negedge i_clk) begin
    cyc++;
    if (!i_rstn) begin
      last_done = -1;
    end else begin
      if (o_sdram_en) begin
        en_cnt++;
        check("en_not_back_to_back", {31'b0, prev_en}, 0);
        if (last_done >= 0) check("gap_before_grant", {31'b0, (cyc - last_done - 1) >= GAP}, 1);
      end
      if (o_wr_done) wdone_cnt++;
      if (o_wr_done || o_rd_done) last_done = cyc;
    end
    prev_en = o_sdram_en;
  end

  task automatic wait_grant(input bit exp_rw, input logic [AW-1:0] exp_addr, input int limit);
    int n = 0;
    while (!o_sdram_en && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    check("grant_seen", {31'b0, o_sdram_en}, 1);
    check("grant_rw", {31'b0, o_rw}, {31'b0, exp_rw});
    check("grant_addr", {17'b0, o_addr}, {17'b0, exp_addr});
    check("wr_ack", {31'b0, o_wr_ack}, {31'b0, !exp_rw});
    check("rd_ack", {31'b0, o_rd_ack}, {31'b0, exp_rw});
    check("busy_issue", {31'b0, o_busy}, 1);
    if (exp_rw) i_rd_req = 1'b0;
    else i_wr_req = 1'b0;
    @(negedge i_clk);
    check("en_pulse_end", {31'b0, o_sdram_en}, 0);
    check("ack_pulse_end", {30'b0, o_wr_ack, o_rd_ack}, 0);
  endtask

  task automatic write_burst(input int base, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (i % 7 == 3) begin
        i_writing = 1'b0;
        #1 check("pop_on_stall", {31'b0, o_wr_pop}, 0);
        @(negedge i_clk);
      end
      i_writing = 1'b1;
      i_wr_data = DW'(base + i);
      #1;
      check("pop", {31'b0, o_wr_pop}, 1);
      check("datain", {16'b0, o_datain}, 32'(DW'(base + i)));
      check("wr_done_early", {31'b0, o_wr_done}, 0);
      @(negedge i_clk);
    end
    i_writing = 1'b0;
    i_wr_data = '0;
  endtask

  task automatic read_burst(input int base, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (i % 7 == 3) begin
        i_dataval = 1'b0;
        @(negedge i_clk);
        check("valid_on_stall", {31'b0, o_rd_valid}, 0);
      end
      i_dataval = 1'b1;
      i_dataout = DW'(base + i);
      @(negedge i_clk);
      check("rd_valid", {31'b0, o_rd_valid}, 1);
      check("rd_data", {16'b0, o_rd_data}, 32'(DW'(base + i)));
      check("rd_done", {31'b0, o_rd_done}, (i == int'(BL) - 1) ? 1 : 0);
    end
    i_dataval = 1'b0;
    i_dataout = '0;
  endtask

  typedef struct {
    bit            wr;
    bit            rd;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    bit            exp_rw;
    logic [AW-1:0] exp_addr;
    int            base;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 0, 15'h0000, 15'h0000, 0, 15'h0000, 777};
    vecs[1] = '{0, 1, 15'h0000, 15'h0200, 1, 15'h0200, 777};
    vecs[2] = '{1, 1, 15'h0100, 15'h0300, 0, 15'h0100, 1000};
    vecs[3] = '{1, 1, 15'h0100, 15'h0300, 1, 15'h0300, 2000};
    vecs[4] = '{1, 1, 15'h0140, 15'h0340, 0, 15'h0140, 3000};
    vecs[5] = '{1, 1, 15'h0140, 15'h0340, 1, 15'h0340, 4000};
    vecs[6] = '{0, 1, 15'h0000, 15'h0050, 1, 15'h0050, 5000};
    vecs[7] = '{1, 1, 15'h7fff, 15'h0123, 0, 15'h7fff, 6000};

    repeat (3) @(negedge i_clk);
    check("rst_busy", {31'b0, o_busy}, 0);
    check("rst_en", {31'b0, o_sdram_en}, 0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("idle_busy", {31'b0, o_busy}, 0);
    check("idle_err", {31'b0, o_err}, 0);

    for (int r = 0; r < 8; r++) begin
      i_wr_req  = vecs[r].wr;
      i_rd_req  = vecs[r].rd;
      i_wr_addr = vecs[r].wa;
      i_rd_addr = vecs[r].ra;
      wait_grant(vecs[r].exp_rw, vecs[r].exp_addr, 20);
      if (vecs[r].exp_rw) begin
        read_burst(vecs[r].base, BL);
        @(negedge i_clk);
        check("rd_valid_after", {31'b0, o_rd_valid}, 0);
        check("rd_done_pulse", {31'b0, o_rd_done}, 0);
      end else begin
        write_burst(vecs[r].base, BL);
        check("wr_done", {31'b0, o_wr_done}, 1);
        @(negedge i_clk);
        check("wr_done_pulse", {31'b0, o_wr_done}, 0);
      end
      check("addr_hold", {17'b0, o_addr}, {17'b0, vecs[r].exp_addr});
      check("rw_hold", {31'b0, o_rw}, {31'b0, vecs[r].exp_rw});
    end
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    repeat (4) @(negedge i_clk);

    // i_ready low blocks arbitration
    begin
      int en_before;
      en_before = en_cnt;
      i_ready   = 1'b0;
      i_wr_req  = 1'b1;
      i_wr_addr = 15'h0abc;
      repeat (100) @(negedge i_clk);
      check("no_grant_not_ready", 32'(en_cnt - en_before), 0);
      check("idle_not_ready", {31'b0, o_busy}, 0);
      i_ready = 1'b1;
      wait_grant(0, 15'h0abc, 2);
      write_burst(100, BL);
      check("wr_done_ready", {31'b0, o_wr_done}, 1);
      repeat (4) @(negedge i_clk);
    end

    // Timeout: only 10 beats arrive; read pending wins afterwards even with write also requesting
    begin
      int k, wd_before;
      i_wr_req  = 1'b1;
      i_wr_addr = 15'h0555;
      wait_grant(0, 15'h0555, 20);
      wd_before = wdone_cnt;
      i_rd_req  = 1'b1;
      i_rd_addr = 15'h0666;
      i_wr_req  = 1'b1;
      i_wr_addr = 15'h0777;
      k = 0;
      while (!o_err && k < 200) begin
        i_writing = (k < 10);
        i_wr_data = DW'(200 + k);
        if (k == 40) check("err_early", {31'b0, o_err}, 0);
        @(negedge i_clk);
        k++;
      end
      i_writing = 1'b0;
      check("tmo_cycle", 32'(k), TMO);
      check("err_set", {31'b0, o_err}, 1);
      check("no_done_on_tmo", 32'(wdone_cnt - wd_before), 0);
      wait_grant(1, 15'h0666, 20);
      check("err_sticky", {31'b0, o_err}, 1);
      read_burst(500, 20);
    end

    // Reset mid-read clears everything at once
    i_rstn = 1'b0;
    #1;
    check("rst_en_mid", {31'b0, o_sdram_en}, 0);
    check("rst_acks", {30'b0, o_wr_ack, o_rd_ack}, 0);
    check("rst_pop", {31'b0, o_wr_pop}, 0);
    check("rst_dones", {30'b0, o_wr_done, o_rd_done}, 0);
    check("rst_rd", {15'b0, o_rd_valid, o_rd_data}, 0);
    check("rst_err", {31'b0, o_err}, 0);
    check("rst_busy_mid", {31'b0, o_busy}, 0);
    check("rst_addr_rw", {16'b0, o_addr, o_rw}, 0);
    check("rst_datain", {16'b0, o_datain}, 0);
    i_wr_addr = 15'h0321;
    i_rd_req  = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    wait_grant(0, 15'h0321, 10);
    write_burst(7000, BL);
    check("wr_done_post_rst", {31'b0, o_wr_done}, 1);
    check("err_clear_post_rst", {31'b0, o_err}, 0);
    repeat (4) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
